wav_sample_fifo: RTL and testbench

- Upstream neighbour of the I2S DAC serializer.
- Takes the raw byte stream from the SD-card file reader, skips the WAV header, and packs little-endian byte pairs into 16-bit PCM samples.
- Buffers the samples in an on-chip FIFO and presents one sample on wav_data for each serializer read request (myvalid pulse).
- Requests more SD data whenever the fill level drops below a low-water mark.

---
 rtl/wav_sample_fifo.sv | 121 ++++++++++++
 tb/tb_wav_sample_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wav_sample_fifo.sv
// WAV byte-stream to 16-bit PCM sample FIFO for the I2S serializer.
// Skips the file header, packs little-endian byte pairs, buffers samples.
module wav_sample_fifo #(
    parameter int ADDR_W    = 9,
    parameter int LOW_MARK  = 128,
    parameter int HDR_BYTES = 44
) (
    input  logic              clock_50M,
    input  logic              rst,
    input  logic              file_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              myvalid,
    output logic [15:0]       wav_data,
    output logic              need_data,
    output logic [ADDR_W:0]   level,
    output logic              underrun,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int HW    = (HDR_BYTES < 2) ? 1 : $clog2(HDR_BYTES + 1);
    localparam logic [HW-1:0]   HDR_INIT = HW'(HDR_BYTES);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LOW_LVL  = (ADDR_W + 1)'(LOW_MARK);

    typedef enum logic [1:0] {SKIP, LOW, HIGH} state_t;

    state_t            state;
    logic [HW-1:0]     hdr_cnt;
    logic [7:0]        lo_byte;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       mem [DEPTH];

    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_req;
    logic              wr_ok;
    logic [ADDR_W:0]   level_next;

    assign full   = (level == FULL_LVL);
    assign empty  = (level == '0);
    assign rd_ok  = myvalid && !empty && !file_start;
    assign wr_req = byte_valid && (state == HIGH) && !file_start;
    // A read in the same cycle frees a slot, so a full FIFO still accepts
    assign wr_ok  = wr_req && (!full || rd_ok);

    always_comb begin
        level_next = level;
        if (wr_ok && !rd_ok)
            level_next = level + 1'b1;
        else if (rd_ok && !wr_ok)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clock_50M) begin
        if (wr_ok)
            mem[wr_ptr] <= {byte_data, lo_byte};
    end

    always_ff @(posedge clock_50M or posedge rst) begin
        if (rst) begin
            state     <= LOW;
            hdr_cnt   <= HDR_INIT;
            lo_byte   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            wav_data  <= '0;
            need_data <= 1'b1;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else if (file_start) begin
            state     <= (HDR_BYTES == 0) ? LOW : SKIP;
            hdr_cnt   <= HDR_INIT;
            lo_byte   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            wav_data  <= '0;
            need_data <= 1'b1;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (myvalid) begin
                if (!empty) begin
                    wav_data <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    wav_data <= '0;
                    underrun <= 1'b1;
                end
            end
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr_req && !wr_ok)
                overflow <= 1'b1;
            level     <= level_next;
            need_data <= (level_next < LOW_LVL);
            if (byte_valid) begin
                unique case (state)
                    SKIP: begin
                        if (hdr_cnt <= HW'(1))
                            state <= LOW;
                        if (hdr_cnt != '0)
                            hdr_cnt <= hdr_cnt - HW'(1);
                    end
                    LOW: begin
                        lo_byte <= byte_data;
                        state   <= HIGH;
                    end
                    HIGH: state <= LOW;
                    default: state <= LOW;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wav_sample_fifo.sv
// Self-checking bench for wav_sample_fifo: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wav_sample_fifo;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int LOWM  = 128;
    localparam int HDR   = 44;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        bv;
    logic [7:0]  bd;
    logic        mv;
    logic [15:0] wav;
    logic        need;
    logic [AW:0] lvl;
    logic        und;
    logic        ovf;

    always #10 clk = ~clk;

    wav_sample_fifo #(.ADDR_W(AW), .LOW_MARK(LOWM), .HDR_BYTES(HDR)) dut (
        .clock_50M (clk),
        .rst       (rst),
        .file_start(fs),
        .byte_valid(bv),
        .byte_data (bd),
        .myvalid   (mv),
        .wav_data  (wav),
        .need_data (need),
        .level     (lvl),
        .underrun  (und),
        .overflow  (ovf)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: sample queue plus header/byte-pair bookkeeping
    int q[$];
    int m_hdr;
    bit m_hi;
    int m_lo;
    int m_wav;
    bit m_und;
    bit m_ovf;
    bit m_need;

    function automatic void model_reset();
        q.delete();
        m_hdr  = 0;
        m_hi   = 0;
        m_lo   = 0;
        m_wav  = 0;
        m_und  = 0;
        m_ovf  = 0;
        m_need = 1;
    endfunction

    function automatic void model_step(bit f, bit v, int d, bit r);
        if (f) begin
            q.delete();
            m_hdr  = HDR;
            m_hi   = 0;
            m_wav  = 0;
            m_und  = 0;
            m_ovf  = 0;
            m_need = 1;
            return;
        end
        if (r) begin
            if (q.size() > 0) begin
                m_wav = q.pop_front();
            end else begin
                m_wav = 0;
                m_und = 1;
            end
        end
        if (v) begin
            if (m_hdr > 0) begin
                m_hdr--;
            end else if (!m_hi) begin
                m_lo = d;
                m_hi = 1;
            end else begin
                m_hi = 0;
                if (q.size() < DEPTH) q.push_back(d * 256 + m_lo);
                else m_ovf = 1;
            end
        end
        m_need = (q.size() < LOWM);
    endfunction

    task automatic cyc(input bit f, input bit v, input int d, input bit r);
        fs = f;
        bv = v;
        bd = d[7:0];
        mv = r;
        @(posedge clk);
        #1;
        model_step(f, v, d & 255, r);
        fs = 0;
        bv = 0;
        mv = 0;
    endtask

    task automatic chk_model(input string name);
        tests++;
        if (wav !== 16'(m_wav) || lvl !== 10'(q.size()) || need !== m_need ||
            und !== m_und || ovf !== m_ovf) begin
            fails++;
            $display("FAIL %s: got wav=%h lvl=%0d need=%b und=%b ovf=%b, want wav=%h lvl=%0d need=%b und=%b ovf=%b",
                     name, wav, lvl, need, und, ovf,
                     16'(m_wav), q.size(), m_need, m_und, m_ovf);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    typedef struct {
        bit          f;
        bit          v;
        int          d;
        bit          r;
        logic [15:0] w;
        int          l;
        bit          n;
        bit          u;
        bit          o;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit f, bit v, int d, bit r,
                                int w, int l, bit n, bit u, bit o);
        vec_t e;
        e.f = f; e.v = v; e.d = d; e.r = r;
        e.w = 16'(w); e.l = l; e.n = n; e.u = u; e.o = o;
        tbl.push_back(e);
    endfunction

    task automatic send_hdr(input int val);
        for (int i = 0; i < HDR; i++) cyc(0, 1, val, 0);
    endtask

    task automatic send_sample(input int s);
        cyc(0, 1, s & 255, 0);
        cyc(0, 1, (s >> 8) & 255, 0);
    endtask

    initial begin
        int mvp;
        rst = 1; fs = 0; bv = 0; bd = 0; mv = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wav", wav, 0);
        chk("reset_lvl", lvl, 0);
        chk("reset_need", need, 1);
        chk("reset_flags", {und, ovf}, 0);
        rst = 0;

        // Basic packing, header integrity, underrun, mid-pair file_start
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < HDR; i++) add(0, 1, i + 3, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h34, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h12, 0, 0, 1, 1, 0, 0);
        add(0, 1, 'h78, 0, 0, 1, 1, 0, 0);
        add(0, 1, 'h56, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 1, 'h1234, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h5678, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < HDR; i++) add(0, 1, 'hFF, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h01, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h00, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h0001, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 'h33, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < HDR; i++) add(0, 1, 'h5A, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'hAA, 0, 0, 0, 1, 0, 0);
        add(1, 1, 'hBB, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < HDR - 1; i++) add(0, 1, 'h11, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h22, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h34, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'h12, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h1234, 0, 1, 0, 0);

        foreach (tbl[k]) begin
            cyc(tbl[k].f, tbl[k].v, tbl[k].d, tbl[k].r);
            tests++;
            if (wav !== tbl[k].w || lvl !== 10'(tbl[k].l) || need !== tbl[k].n ||
                und !== tbl[k].u || ovf !== tbl[k].o) begin
                fails++;
                $display("FAIL vec%0d: got wav=%h lvl=%0d need=%b und=%b ovf=%b, want wav=%h lvl=%0d need=%b und=%b ovf=%b",
                         k, wav, lvl, need, und, ovf,
                         tbl[k].w, tbl[k].l, tbl[k].n, tbl[k].u, tbl[k].o);
            end
        end

        // Overfill by one, then drain across the pointer wrap
        cyc(1, 0, 0, 0);
        send_hdr(0);
        for (int s = 0; s <= DEPTH; s++) send_sample(s);
        chk("fill_lvl", lvl, DEPTH);
        chk("fill_ovf", ovf, 1);
        chk("fill_need", need, 0);
        chk_model("fill_model");
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 1);
            chk("drain_data", wav, i);
            chk_model("drain_model");
        end
        chk("drain_need", need, 1);

        // Read and write at level 0: no bypass
        cyc(0, 1, 'h99, 0);
        cyc(0, 1, 'h88, 1);
        chk("rw_empty_wav", wav, 0);
        chk("rw_empty_und", und, 1);
        chk("rw_empty_lvl", lvl, 1);

        // Read and write at level 5
        cyc(1, 0, 0, 0);
        send_hdr(7);
        for (int s = 0; s < 5; s++) send_sample(100 + s);
        cyc(0, 1, 200, 0);
        cyc(0, 1, 0, 1);
        chk("rw5_lvl", lvl, 5);
        chk("rw5_wav", wav, 100);
        chk_model("rw5_model");

        // Read and write at full
        cyc(1, 0, 0, 0);
        send_hdr(1);
        for (int s = 0; s < DEPTH; s++) send_sample('h1000 + s);
        cyc(0, 1, 'hCD, 0);
        cyc(0, 1, 'hAB, 1);
        chk("rwfull_lvl", lvl, DEPTH);
        chk("rwfull_ovf", ovf, 0);
        chk("rwfull_wav", wav, 'h1000);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 1);
            chk_model("rwfull_drain");
        end
        chk("rwfull_last", wav, 'hABCD);

        // Asynchronous reset mid-sample
        cyc(1, 0, 0, 0);
        send_hdr(2);
        send_sample('h4321);
        cyc(0, 1, 'h77, 0);
        #5 rst = 1;
        #1;
        chk("arst_lvl", lvl, 0);
        chk("arst_need", need, 1);
        chk("arst_wav", wav, 0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cyc(1, 0, 0, 0);
        send_hdr(4);
        send_sample('h0102);
        cyc(0, 0, 0, 1);
        chk("arst_after", wav, 'h0102);

        // Randomized traffic against the reference model
        cyc(1, 0, 0, 0);
        chk_model("rand_start");
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: mvp = 5;
                    1: mvp = 30;
                    default: mvp = 60;
                endcase
            end
            cyc($urandom_range(0, 699) == 0,
                $urandom_range(0, 99) < 80,
                int'($urandom_range(0, 255)),
                $urandom_range(0, 99) < mvp);
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
